// File: rtl/m68k_bus_arbiter.sv
// 68000 BR/BG/BGACK arbiter: lends the bus to external DMA masters, gates
// Pi-initiated cycle starts while the bus is away and counts completed tenures.
//
// state     | meaning
// OWNED     | Pistorm holds the bus, cycles may start
// DRAIN     | request seen mid-cycle, waiting for the cycle to finish
// PI_FIRST  | one pending Pi cycle allowed before the grant
// GRANT     | BG asserted, waiting for BGACK or timeout
// RELEASED  | external master owns the bus
// RECLAIM   | settle cycle before taking the bus back
module m68k_bus_arbiter #(
   parameter int SYNC_STAGES   = 2,
   parameter int GRANT_TIMEOUT = 15,
   parameter bit PI_PRIORITY   = 1'b1
) (
   input  logic       c7m,
   input  logic       op_reqrst,
   input  logic       op_req,
   input  logic       bus_idle,
   input  logic       M68K_BR_n,
   input  logic       M68K_BGACK_n,
   input  logic       M68K_AS_n_in,
   output logic       M68K_BG_n,
   output logic       bus_owned,
   output logic [2:0] arb_state,
   output logic [7:0] grant_count
);

   localparam int TW = ($clog2(GRANT_TIMEOUT + 1) > 4) ? $clog2(GRANT_TIMEOUT + 1) : 4;
   localparam logic [TW-1:0] TMO_LAST = TW'(GRANT_TIMEOUT);

   typedef enum logic [2:0] {
      ST_OWNED    = 3'd0,
      ST_DRAIN    = 3'd1,
      ST_PI_FIRST = 3'd2,
      ST_GRANT    = 3'd3,
      ST_RELEASED = 3'd4,
      ST_RECLAIM  = 3'd5
   } arb_state_t;

   arb_state_t             state_q, state_d;
   logic                   bg_n_q, bg_n_d;
   logic                   owned_q, owned_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic [7:0]             gcnt_q, gcnt_d;
   logic [SYNC_STAGES-1:0] br_sync_q, br_sync_d;
   logic [SYNC_STAGES-1:0] bgack_sync_q, bgack_sync_d;
   logic                   as_n_q, as_n_d;
   logic                   block_q, block_d;
   logic                   hold_q, hold_d;
   logic                   rel_q, rel_d;
   logic                   started_q, started_d;

   logic          br;
   logic          bgack;
   logic          br_eff;
   logic [TW-1:0] tmo_inc;

   assign br      = ~br_sync_q[SYNC_STAGES-1];
   assign bgack   = ~bgack_sync_q[SYNC_STAGES-1];
   assign br_eff  = br & ~block_q;
   assign tmo_inc = tmo_q + 1'b1;

   always_comb begin
      br_sync_d       = br_sync_q;
      bgack_sync_d    = bgack_sync_q;
      br_sync_d[0]    = M68K_BR_n;
      bgack_sync_d[0] = M68K_BGACK_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         br_sync_d[i]    = br_sync_q[i-1];
         bgack_sync_d[i] = bgack_sync_q[i-1];
      end
      as_n_d    = M68K_AS_n_in;
      state_d   = state_q;
      bg_n_d    = bg_n_q;
      owned_d   = owned_q;
      tmo_d     = tmo_q;
      gcnt_d    = gcnt_q;
      block_d   = block_q & br;
      hold_d    = hold_q;
      rel_d     = rel_q;
      started_d = started_q;

      case (state_q)
         ST_OWNED: begin
            bg_n_d  = 1'b1;
            owned_d = 1'b1;
            if (hold_q) begin
               hold_d = 1'b0;
            end else if (br_eff) begin
               if (!bus_idle) begin
                  state_d = ST_DRAIN;
                  owned_d = 1'b0;
               end else if (PI_PRIORITY && op_req) begin
                  state_d   = ST_PI_FIRST;
                  started_d = 1'b0;
               end else begin
                  state_d = ST_GRANT;
                  bg_n_d  = 1'b0;
                  owned_d = 1'b0;
                  tmo_d   = '0;
               end
            end
         end
         ST_DRAIN: begin
            if (bus_idle) begin
               state_d = ST_GRANT;
               bg_n_d  = 1'b0;
               tmo_d   = '0;
            end
         end
         ST_PI_FIRST: begin
            // A withdrawn Pi request must not strand the pending bus request.
            if (!bus_idle) begin
               owned_d   = 1'b0;
               started_d = 1'b1;
            end else if (started_q || !op_req) begin
               state_d = ST_GRANT;
               bg_n_d  = 1'b0;
               owned_d = 1'b0;
               tmo_d   = '0;
            end
         end
         ST_GRANT: begin
            tmo_d = tmo_inc;
            if (bgack) begin
               state_d = ST_RELEASED;
               bg_n_d  = 1'b1;
            end else if (!br) begin
               state_d = ST_RECLAIM;
               bg_n_d  = 1'b1;
               rel_d   = 1'b0;
            end else if (tmo_inc == TMO_LAST) begin
               state_d = ST_RECLAIM;
               bg_n_d  = 1'b1;
               rel_d   = 1'b0;
               block_d = 1'b1;
            end
         end
         ST_RELEASED: begin
            bg_n_d = 1'b1;
            if (!bgack) begin
               state_d = ST_RECLAIM;
               rel_d   = 1'b1;
            end
         end
         ST_RECLAIM: begin
            bg_n_d = 1'b1;
            if (as_n_q) begin
               state_d = ST_OWNED;
               owned_d = 1'b1;
               hold_d  = 1'b1;
               if (rel_q && gcnt_q != 8'hFF) gcnt_d = gcnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_OWNED;
            bg_n_d  = 1'b1;
            owned_d = 1'b1;
            hold_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge c7m or posedge op_reqrst) begin
      if (op_reqrst) begin
         state_q      <= ST_OWNED;
         bg_n_q       <= 1'b1;
         owned_q      <= 1'b1;
         tmo_q        <= '0;
         gcnt_q       <= 8'd0;
         br_sync_q    <= '1;
         bgack_sync_q <= '1;
         as_n_q       <= 1'b1;
         block_q      <= 1'b0;
         hold_q       <= 1'b0;
         rel_q        <= 1'b0;
         started_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bg_n_q       <= bg_n_d;
         owned_q      <= owned_d;
         tmo_q        <= tmo_d;
         gcnt_q       <= gcnt_d;
         br_sync_q    <= br_sync_d;
         bgack_sync_q <= bgack_sync_d;
         as_n_q       <= as_n_d;
         block_q      <= block_d;
         hold_q       <= hold_d;
         rel_q        <= rel_d;
         started_q    <= started_d;
      end
   end

   assign M68K_BG_n   = bg_n_q;
   assign bus_owned   = owned_q;
   assign arb_state   = state_q;
   assign grant_count = gcnt_q;

endmodule
